stencil_writeback: RTL and testbench

STENCIL_WRITEBACK -- requirements
Module: stencil_writeback

---
 rtl/tauri_stencil_pkg.sv | 23 ++
 rtl/stencil_op_alu.sv | 27 ++
 rtl/stencil_writeback.sv | 136 +++++++++++++
 tb/tb_stencil_writeback.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tauri_stencil_pkg.sv
// Shared stencil definitions: operation encoding, data width and writeback FSM states.
package tauri_stencil_pkg;

  localparam int unsigned STENCIL_W = 8;

  typedef enum logic [2:0] {
    KEEP      = 3'd0,
    ZERO      = 3'd1,
    REPLACE   = 3'd2,
    INCR      = 3'd3,
    DECR      = 3'd4,
    INVERT    = 3'd5,
    INCR_WRAP = 3'd6,
    DECR_WRAP = 3'd7
  } stencil_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } wb_state_e;

endpackage

// File: rtl/stencil_op_alu.sv
// Combinational stencil operation evaluator: r = op(s, ref_val).
module stencil_op_alu
  import tauri_stencil_pkg::*;
(
  input  logic [2:0]           op,
  input  logic [STENCIL_W-1:0] s,
  input  logic [STENCIL_W-1:0] ref_val,
  output logic [STENCIL_W-1:0] r
);

  // Evaluate the selected stencil operation on the old value.
  always_comb begin
    r = s;
    case (stencil_op_e'(op))
      KEEP:      r = s;
      ZERO:      r = '0;
      REPLACE:   r = ref_val;
      INCR:      r = (s == '1) ? s : s + STENCIL_W'(1);
      DECR:      r = (s == '0) ? s : s - STENCIL_W'(1);
      INVERT:    r = ~s;
      INCR_WRAP: r = s + STENCIL_W'(1);
      DECR_WRAP: r = s - STENCIL_W'(1);
      default:   r = s;
    endcase
  end

endmodule

// File: rtl/stencil_writeback.sv
// Stencil writeback: applies stencil ops to fragment results, elides no-op
// writes, and performs a full-buffer clear sweep on request.
module stencil_writeback
  import tauri_stencil_pkg::*;
#(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned NUM_PIXELS = 65536
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 frag_valid_i,
  output logic                 frag_ready_o,
  input  logic [ADDR_W-1:0]    frag_addr_i,
  input  logic [STENCIL_W-1:0] frag_stencil_i,
  input  logic                 stencil_pass_i,
  input  logic                 depth_pass_i,
  input  logic [STENCIL_W-1:0] ref_val_i,
  input  logic [STENCIL_W-1:0] write_mask_i,
  input  logic [2:0]           op_sfail_i,
  input  logic [2:0]           op_dpfail_i,
  input  logic [2:0]           op_dppass_i,
  input  logic                 clear_i,
  input  logic [STENCIL_W-1:0] clear_val_i,
  output logic                 busy_o,
  output logic                 wr_valid_o,
  input  logic                 wr_ready_i,
  output logic [ADDR_W-1:0]    wr_addr_o,
  output logic [STENCIL_W-1:0] wr_data_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

  wb_state_e              state_q, state_d;
  logic                   wr_valid_d;
  logic [ADDR_W-1:0]      wr_addr_d;
  logic [STENCIL_W-1:0]   wr_data_d;
  logic [STENCIL_W-1:0]   clr_val_q, clr_val_d;
  logic [ADDR_W-1:0]      clr_cnt_q, clr_cnt_d;

  logic [2:0]             op_sel;
  logic [STENCIL_W-1:0]   op_res;
  logic [STENCIL_W-1:0]   new_val;
  logic                   out_free;
  logic                   frag_fire;

  // Pick the op according to which test failed first.
  always_comb begin
    op_sel = op_dppass_i;
    if (!stencil_pass_i)    op_sel = op_sfail_i;
    else if (!depth_pass_i) op_sel = op_dpfail_i;
  end

  stencil_op_alu u_alu (
    .op      (op_sel),
    .s       (frag_stencil_i),
    .ref_val (ref_val_i),
    .r       (op_res)
  );

  assign new_val      = (frag_stencil_i & ~write_mask_i) | (op_res & write_mask_i);
  assign out_free     = !wr_valid_o || wr_ready_i;
  assign frag_ready_o = (state_q == IDLE) && out_free;
  assign frag_fire    = frag_valid_i && frag_ready_o;
  assign busy_o       = (state_q != IDLE) || wr_valid_o;

  // Next-state and output-register logic for fragment writes and the clear sweep.
  always_comb begin
    state_d    = state_q;
    wr_valid_d = wr_valid_o;
    wr_addr_d  = wr_addr_o;
    wr_data_d  = wr_data_o;
    clr_val_d  = clr_val_q;
    clr_cnt_d  = clr_cnt_q;
    case (state_q)
      IDLE: begin
        if (wr_valid_o && wr_ready_i) wr_valid_d = 1'b0;
        if (frag_fire && (new_val != frag_stencil_i)) begin
          wr_valid_d = 1'b1;
          wr_addr_d  = frag_addr_i;
          wr_data_d  = new_val;
        end
        // A fragment in the same cycle is taken first; DRAIN waits for its write.
        if (clear_i) begin
          state_d   = DRAIN;
          clr_val_d = clear_val_i;
        end
      end
      DRAIN: begin
        // The sweep's first write is launched as the last fragment write retires.
        if (out_free) begin
          state_d    = CLEAR;
          wr_valid_d = 1'b1;
          wr_addr_d  = '0;
          wr_data_d  = clr_val_q;
          clr_cnt_d  = '0;
        end
      end
      CLEAR: begin
        if (wr_ready_i) begin
          if (clr_cnt_q == LAST_ADDR) begin
            state_d    = IDLE;
            wr_valid_d = 1'b0;
          end else begin
            clr_cnt_d = clr_cnt_q + ADDR_W'(1);
            wr_addr_d = clr_cnt_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Write port and clear bookkeeping registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_valid_o <= 1'b0;
      wr_addr_o  <= '0;
      wr_data_o  <= '0;
      clr_val_q  <= '0;
      clr_cnt_q  <= '0;
    end else begin
      wr_valid_o <= wr_valid_d;
      wr_addr_o  <= wr_addr_d;
      wr_data_o  <= wr_data_d;
      clr_val_q  <= clr_val_d;
      clr_cnt_q  <= clr_cnt_d;
    end
  end

endmodule

// File: tb/tb_stencil_writeback.sv
// Directed self-checking bench for stencil_writeback.
module tb_stencil_writeback;
  import tauri_stencil_pkg::*;

  localparam int unsigned AW = 8;
  localparam int unsigned NP = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          frag_valid;
  logic          frag_ready;
  logic [AW-1:0] frag_addr;
  logic [7:0]    frag_stencil;
  logic          stencil_pass;
  logic          depth_pass;
  logic [7:0]    ref_val;
  logic [7:0]    write_mask;
  logic [2:0]    op_sfail;
  logic [2:0]    op_dpfail;
  logic [2:0]    op_dppass;
  logic          clear;
  logic [7:0]    clear_val;
  logic          busy;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;

  int unsigned vec_cnt = 0;
  int unsigned err_cnt = 0;
  logic [15:0] wlog[$];

  always #5 clk = ~clk;

  stencil_writeback #(.ADDR_W(AW), .NUM_PIXELS(NP)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .frag_valid_i   (frag_valid),
    .frag_ready_o   (frag_ready),
    .frag_addr_i    (frag_addr),
    .frag_stencil_i (frag_stencil),
    .stencil_pass_i (stencil_pass),
    .depth_pass_i   (depth_pass),
    .ref_val_i      (ref_val),
    .write_mask_i   (write_mask),
    .op_sfail_i     (op_sfail),
    .op_dpfail_i    (op_dpfail),
    .op_dppass_i    (op_dppass),
    .clear_i        (clear),
    .clear_val_i    (clear_val),
    .busy_o         (busy),
    .wr_valid_o     (wr_valid),
    .wr_ready_i     (wr_ready),
    .wr_addr_o      (wr_addr),
    .wr_data_o      (wr_data)
  );

  // Record every completed write handshake as {addr, data}.
  always @(posedge clk)
    if (rst_n && wr_valid && wr_ready) wlog.push_back({wr_addr, wr_data});

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_log(input string tag, input int idx, input logic [15:0] exp);
    logic [31:0] got;
    got = (idx < wlog.size()) ? {16'h0, wlog[idx]} : 32'hDEAD_BEEF;
    chk(tag, got, {16'h0, exp});
  endtask

  task automatic set_frag(input logic [7:0] a, input logic [7:0] s, input logic sp,
                          input logic dp, input logic [7:0] rf, input logic [7:0] m,
                          input logic [2:0] op);
    frag_addr    = a;
    frag_stencil = s;
    stencil_pass = sp;
    depth_pass   = dp;
    ref_val      = rf;
    write_mask   = m;
    op_sfail     = KEEP;
    op_dpfail    = KEEP;
    op_dppass    = KEEP;
    if (!sp)      op_sfail  = op;
    else if (!dp) op_dpfail = op;
    else          op_dppass = op;
  endtask

  typedef struct {
    logic [7:0] s;
    logic [7:0] rf;
    logic [7:0] m;
    logic       sp;
    logic       dp;
    logic [2:0] op;
    logic       ev;
    logic [7:0] ed;
  } vec_t;

  vec_t vecs[11] = '{
    '{8'hFF, 8'h00, 8'hFF, 1'b1, 1'b1, INCR,      1'b0, 8'h00},
    '{8'hFF, 8'h00, 8'hFF, 1'b1, 1'b1, INCR_WRAP, 1'b1, 8'h00},
    '{8'h0F, 8'hA5, 8'hF0, 1'b0, 1'b1, REPLACE,   1'b1, 8'hAF},
    '{8'h00, 8'h00, 8'hFF, 1'b1, 1'b1, DECR,      1'b0, 8'h00},
    '{8'h00, 8'h00, 8'hFF, 1'b1, 1'b1, DECR_WRAP, 1'b1, 8'hFF},
    '{8'h5A, 8'h00, 8'hFF, 1'b1, 1'b0, INVERT,    1'b1, 8'hA5},
    '{8'h77, 8'h00, 8'h0F, 1'b1, 1'b1, ZERO,      1'b1, 8'h70},
    '{8'h10, 8'h00, 8'hFF, 1'b0, 1'b0, INCR,      1'b1, 8'h11},
    '{8'h33, 8'h33, 8'hFF, 1'b1, 1'b1, REPLACE,   1'b0, 8'h00},
    '{8'h80, 8'h00, 8'h01, 1'b1, 1'b0, INCR,      1'b1, 8'h81},
    '{8'h3C, 8'h99, 8'hFF, 1'b1, 1'b1, KEEP,      1'b0, 8'h00}
  };

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic found;
    int   leak;

    rst_n      = 1'b1;
    frag_valid = 1'b0;
    clear      = 1'b0;
    clear_val  = 8'h00;
    wr_ready   = 1'b1;
    set_frag(8'h00, 8'h00, 1'b1, 1'b1, 8'h00, 8'h00, KEEP);
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_frag_ready", frag_ready, 1);
    rst_n = 1'b1;

    // Op table: one fragment per vector, write port always ready.
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      set_frag(8'h40 + 8'(i), vecs[i].s, vecs[i].sp, vecs[i].dp, vecs[i].rf, vecs[i].m, vecs[i].op);
      frag_valid = 1'b1;
      #1 chk($sformatf("v%0d_ready", i), frag_ready, 1);
      @(posedge clk);
      @(negedge clk);
      frag_valid = 1'b0;
      chk($sformatf("v%0d_wr_valid", i), wr_valid, vecs[i].ev);
      chk($sformatf("v%0d_busy", i), busy, vecs[i].ev);
      if (vecs[i].ev) begin
        chk($sformatf("v%0d_data", i), wr_data, vecs[i].ed);
        chk($sformatf("v%0d_addr", i), wr_addr, 8'h40 + 8'(i));
      end
    end

    // Back-pressure: three back-to-back fragments with the write port stalled.
    @(negedge clk);
    wlog.delete();
    wr_ready = 1'b0;
    set_frag(8'h01, 8'h00, 1'b1, 1'b1, 8'h11, 8'hFF, REPLACE);
    frag_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    set_frag(8'h02, 8'h00, 1'b1, 1'b1, 8'h22, 8'hFF, REPLACE);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_ready_low", frag_ready, 0);
      chk("bp_hold_valid", wr_valid, 1);
      chk("bp_hold_addr", wr_addr, 8'h01);
      chk("bp_hold_data", wr_data, 8'h11);
      @(negedge clk);
    end
    wr_ready = 1'b1;
    #1 chk("bp_ready_rise", frag_ready, 1);
    @(posedge clk);
    @(negedge clk);
    set_frag(8'h03, 8'h00, 1'b1, 1'b1, 8'h33, 8'hFF, REPLACE);
    @(posedge clk);
    @(negedge clk);
    frag_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("bp_idle", wr_valid, 0);
    chk("bp_count", wlog.size(), 3);
    chk_log("bp_w0", 0, 16'h0111);
    chk_log("bp_w1", 1, 16'h0222);
    chk_log("bp_w2", 2, 16'h0333);

    // Clear sweep with the write port toggling ready.
    wlog.delete();
    clear     = 1'b1;
    clear_val = 8'h3C;
    @(posedge clk);
    @(negedge clk);
    clear     = 1'b0;
    clear_val = 8'h00;
    #1;
    chk("clr_ready_low", frag_ready, 0);
    chk("clr_busy", busy, 1);
    for (int c = 0; c < 200; c++) begin
      wr_ready = (c % 2 == 0);
      @(negedge clk);
      if (wlog.size() >= NP || !busy) break;
    end
    wr_ready = 1'b1;
    chk("clr_busy_fall", busy, 0);
    chk("clr_count", wlog.size(), NP);
    for (int i = 0; i < int'(NP); i++)
      chk_log($sformatf("clr_w%0d", i), i, {8'(i), 8'h3C});

    // Clear together with a fragment; a second fragment waits through the sweep.
    @(negedge clk);
    wlog.delete();
    set_frag(8'h05, 8'h01, 1'b1, 1'b1, 8'h00, 8'hFF, DECR);
    frag_valid = 1'b1;
    clear      = 1'b1;
    clear_val  = 8'h5A;
    #1 chk("cf_ready", frag_ready, 1);
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
    set_frag(8'h09, 8'h00, 1'b1, 1'b1, 8'h77, 8'hFF, REPLACE);
    leak = 0;
    for (int c = 0; c < 200; c++) begin
      if (!busy) break;
      if (frag_ready) leak++;
      @(negedge clk);
    end
    frag_valid = 1'b0;
    chk("cf_busy_fall", busy, 0);
    chk("cf_no_accept", leak, 0);
    chk("cf_count", wlog.size(), NP + 1);
    chk_log("cf_frag", 0, 16'h0500);
    for (int i = 0; i < int'(NP); i++)
      chk_log($sformatf("cf_w%0d", i), i + 1, {8'(i), 8'h5A});

    // Reset in the middle of a sweep.
    @(negedge clk);
    clear     = 1'b1;
    clear_val = 8'hC3;
    @(negedge clk);
    clear = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (wr_valid && wr_addr == 8'h03) begin
        found = 1'b1;
        break;
      end
    end
    chk("rc_reach_addr3", found, 1);
    rst_n = 1'b0;
    #1;
    wlog.delete();
    chk("rc_wr_valid", wr_valid, 0);
    chk("rc_busy", busy, 0);
    chk("rc_frag_ready", frag_ready, 1);
    chk("rc_wr_addr", wr_addr, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("rc_no_writes", wlog.size(), 0);
    chk("rc_ready_after", frag_ready, 1);
    chk("rc_busy_after", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
